hdmi_capture_ctrl: RTL and testbench

Sequencer for the HDMI pixel-capture path.
- Holds the capture window size and accepts host commands over a valid/ready interface.
- Arms the capture block with a one-cycle start_write pulse, then counts pixels it pushes into the pixel FIFO.
- Tracks FIFO occupancy against the downstream drain and reports done, overflow or timeout to the host.

---
 rtl/hdmi_cap_pkg.sv | 32 +++
 rtl/hdmi_fifo_level_tracker.sv | 64 ++++++
 rtl/hdmi_capture_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_hdmi_capture_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cap_pkg.sv
// Shared definitions for the HDMI pixel-capture sequencer.
// Holds the host opcode values, the sticky error codes reported on err_code,
// the sequencer state encoding and a helper that classifies busy states.
package hdmi_cap_pkg;

  // Host command opcodes carried on cmd_op
  localparam logic [1:0] CMD_SET_WIDTH  = 2'd0;
  localparam logic [1:0] CMD_SET_HEIGHT = 2'd1;
  localparam logic [1:0] CMD_START      = 2'd2;
  localparam logic [1:0] CMD_ABORT      = 2'd3;

  // Error codes reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_BADCFG   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // A capture is in flight in every state except IDLE and ERROR
  function automatic logic is_busy(input state_e s);
    return (s == ST_ARM) || (s == ST_CAPTURE) || (s == ST_DRAIN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/hdmi_fifo_level_tracker.sv
// Up/down occupancy counter mirroring the pixel FIFO.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wr_en_i      : FIFO write strobe
//   rd_en_i      : FIFO read strobe
//   level_o      : tracked occupancy (0..FIFO_DEPTH)
//   full_o       : level_o == FIFO_DEPTH
//   empty_o      : level_o == 0
//   overflow_o   : a write without a read is arriving while full
module hdmi_fifo_level_tracker #(
  parameter int unsigned FIFO_DEPTH = 1024,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;

  assign full_o     = (level_q == DEPTH_L);
  assign empty_o    = (level_q == {LVL_W{1'b0}});
  assign overflow_o = wr_en_i && !rd_en_i && full_o;

  // Next occupancy: a simultaneous write and read cancel; both ends saturate
  always_comb begin
    level_d = level_q;
    if (wr_en_i && !rd_en_i) begin
      if (!full_o) begin
        level_d = level_q + LVL_W'(1);
      end else begin
        level_d = level_q;
      end
    end else if (rd_en_i && !wr_en_i) begin
      if (!empty_o) begin
        level_d = level_q - LVL_W'(1);
      end else begin
        level_d = level_q;
      end
    end else begin
      level_d = level_q;
    end
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= {LVL_W{1'b0}};
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/hdmi_capture_ctrl.sv
// Sequencer for the HDMI pixel-capture path.
// Accepts host commands, arms the capture block, counts pixels into the
// pixel FIFO, tracks FIFO occupancy and reports done/overflow/timeout.
// Ports:
//   clk, rst                       : pixel clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_arg : host command channel (always ready)
//   start_write                    : one-cycle arm pulse to the capture block
//   cfg_width, cfg_height          : current capture window
//   fifo_wr_en, fifo_rd_en         : FIFO write (capture) and read (drain) strobes
//   fifo_level                     : tracked FIFO occupancy
//   pix_count                      : pixels written in the current capture
//   busy, done, cmd_rejected       : status; done/cmd_rejected are one-cycle pulses
//   err_code                       : sticky error code
module hdmi_capture_ctrl
  import hdmi_cap_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 1024,
  parameter logic [15:0] DEF_WIDTH      = 16'd64,
  parameter logic [15:0] DEF_HEIGHT     = 16'd64,
  parameter int unsigned TIMEOUT_CYCLES = 32'd4194304,
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [15:0]      cmd_arg,
  output logic             start_write,
  output logic [15:0]      cfg_width,
  output logic [15:0]      cfg_height,
  input  logic             fifo_wr_en,
  input  logic             fifo_rd_en,
  output logic [LVL_W-1:0] fifo_level,
  output logic [31:0]      pix_count,
  output logic             busy,
  output logic             done,
  output logic             cmd_rejected,
  output logic [1:0]       err_code
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       width_q, width_d;
  logic [15:0]       height_q, height_d;
  logic [31:0]       pix_q, pix_d;
  logic [31:0]       target_q, target_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [1:0]        err_q, err_d;
  logic              rej_d;
  logic              start_q, done_q, busy_q, rej_q;

  logic              full_s, empty_s, overflow_s;
  logic              abort_s, wr_landed_s, timeout_s;

  hdmi_fifo_level_tracker #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_level (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr_en),
    .rd_en_i    (fifo_rd_en),
    .level_o    (fifo_level),
    .full_o     (full_s),
    .empty_o    (empty_s),
    .overflow_o (overflow_s)
  );

  assign abort_s     = cmd_valid && (cmd_op == CMD_ABORT);
  // A write that actually lands in the FIFO (a write at full only lands with a read)
  assign wr_landed_s = fifo_wr_en && (!full_s || fifo_rd_en);
  // The idle counter is about to reach the limit with no write this cycle
  assign timeout_s   = !fifo_wr_en && (idle_q == IDLE_LAST);

  // Next-state, configuration and status update
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    pix_d    = pix_q;
    target_d = target_q;
    idle_d   = idle_q;
    err_d    = err_q;
    rej_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (cmd_valid) begin
          case (cmd_op)
            CMD_SET_WIDTH:  width_d  = cmd_arg;
            CMD_SET_HEIGHT: height_d = cmd_arg;
            CMD_START: begin
              if ((width_q == 16'd0) || (height_q == 16'd0)) begin
                state_d = ST_ERROR;
                err_d   = ERR_BADCFG;
              end else begin
                state_d  = ST_ARM;
                err_d    = ERR_NONE;
                pix_d    = 32'd0;
                target_d = {16'd0, width_q} * {16'd0, height_q};
              end
            end
            CMD_ABORT: begin
              state_d = ST_IDLE;
              err_d   = ERR_NONE;
            end
            default: state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end

      ST_ARM: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CAPTURE;
          idle_d  = {IDLE_W{1'b0}};
        end
      end

      ST_CAPTURE: begin
        // Precedence: abort, overflow, timeout, then completion
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (overflow_s) begin
          state_d = ST_ERROR;
          err_d   = ERR_OVERFLOW;
        end else if (timeout_s) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else if (wr_landed_s) begin
          pix_d  = pix_q + 32'd1;
          idle_d = {IDLE_W{1'b0}};
          if ((pix_q + 32'd1) == target_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end

      ST_DRAIN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (overflow_s) begin
          state_d = ST_ERROR;
          err_d   = ERR_OVERFLOW;
        end else if (empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // While busy every command except ABORT is dropped and flagged
    if (is_busy(state_q) && cmd_valid && !abort_s) begin
      rej_d = 1'b1;
    end else begin
      rej_d = 1'b0;
    end
  end

  // State, configuration and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      width_q  <= DEF_WIDTH;
      height_q <= DEF_HEIGHT;
      pix_q    <= 32'd0;
      target_q <= 32'd0;
      idle_q   <= {IDLE_W{1'b0}};
      err_q    <= ERR_NONE;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      pix_q    <= pix_d;
      target_q <= target_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      start_q  <= (state_d == ST_ARM);
      done_q   <= (state_d == ST_DONE);
      busy_q   <= is_busy(state_d);
      rej_q    <= rej_d;
    end
  end

  assign cmd_ready    = 1'b1;
  assign start_write  = start_q;
  assign cfg_width    = width_q;
  assign cfg_height   = height_q;
  assign pix_count    = pix_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd_rejected = rej_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_hdmi_capture_ctrl.sv
// Self-checking bench for hdmi_capture_ctrl with a small FIFO and short timeout.
// A behavioural model of the host-visible behaviour is stepped alongside the
// DUT and every output is compared after each clock edge.
module tb_hdmi_capture_ctrl;
  import hdmi_cap_pkg::*;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam int PH_IDLE = 0, PH_ARM = 1, PH_CAP = 2, PH_DRAIN = 3, PH_DONE = 4, PH_ERR = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [15:0]      cmd_arg = 16'd0;
  logic             start_write;
  logic [15:0]      cfg_width, cfg_height;
  logic             fifo_wr_en = 1'b0;
  logic             fifo_rd_en = 1'b0;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      pix_count;
  logic             busy, done, cmd_rejected;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_start = 0;

  // Model state
  int          m_phase;
  int unsigned m_w, m_h, m_target, m_pix;
  int          m_level, m_since, m_err;
  bit          e_start, e_done, e_rej;

  hdmi_capture_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .DEF_WIDTH      (16'd64),
    .DEF_HEIGHT     (16'd64),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .start_write  (start_write),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_level   (fifo_level),
    .pix_count    (pix_count),
    .busy         (busy),
    .done         (done),
    .cmd_rejected (cmd_rejected),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_busy();
    return (m_phase == PH_ARM) || (m_phase == PH_CAP) || (m_phase == PH_DRAIN) || (m_phase == PH_DONE);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_w = 64; m_h = 64; m_target = 0; m_pix = 0;
    m_level = 0; m_since = 0; m_err = 0;
    e_start = 1'b0; e_done = 1'b0; e_rej = 1'b0;
  endtask

  // One clock of host-visible behaviour, written from the command/capture rules
  task automatic model_step(input bit v, input bit [1:0] op, input bit [15:0] arg,
                            input bit wr, input bit rd);
    int  nxt;
    int  lvl_n;
    bit  ovf;
    ovf = wr && !rd && (m_level == DEPTH);
    if (wr && !rd && !ovf)              lvl_n = m_level + 1;
    else if (rd && !wr && m_level > 0)  lvl_n = m_level - 1;
    else                                lvl_n = m_level;
    nxt   = m_phase;
    e_rej = 1'b0;
    if (!model_busy()) begin
      if (v) begin
        if (op == CMD_SET_WIDTH)       m_w = arg;
        else if (op == CMD_SET_HEIGHT) m_h = arg;
        else if (op == CMD_START) begin
          if (m_w == 0 || m_h == 0) begin nxt = PH_ERR; m_err = 3; end
          else begin nxt = PH_ARM; m_err = 0; m_pix = 0; m_target = m_w * m_h; end
        end else begin nxt = PH_IDLE; m_err = 0; end
      end
    end else if (v && op == CMD_ABORT) begin
      nxt = PH_IDLE;
    end else begin
      if (v) e_rej = 1'b1;
      if (m_phase == PH_ARM) begin
        nxt = PH_CAP; m_since = 0;
      end else if (m_phase == PH_CAP) begin
        if (ovf) begin nxt = PH_ERR; m_err = 1; end
        else if (wr) begin
          m_pix++; m_since = 0;
          if (m_pix == m_target) nxt = PH_DRAIN;
        end else begin
          m_since++;
          if (m_since == TMO) begin nxt = PH_ERR; m_err = 2; end
        end
      end else if (m_phase == PH_DRAIN) begin
        if (ovf) begin nxt = PH_ERR; m_err = 1; end
        else if (m_level == 0) nxt = PH_DONE;
      end else begin
        nxt = PH_IDLE;
      end
    end
    m_level = lvl_n;
    m_phase = nxt;
    e_start = (nxt == PH_ARM);
    e_done  = (nxt == PH_DONE);
  endtask

  task automatic check_all();
    chk("cmd_ready",    cmd_ready,    32'd1);
    chk("start_write",  start_write,  e_start);
    chk("cfg_width",    cfg_width,    m_w);
    chk("cfg_height",   cfg_height,   m_h);
    chk("fifo_level",   fifo_level,   m_level);
    chk("pix_count",    pix_count,    m_pix);
    chk("busy",         busy,         model_busy());
    chk("done",         done,         e_done);
    chk("cmd_rejected", cmd_rejected, e_rej);
    chk("err_code",     err_code,     m_err);
  endtask

  task automatic step(input bit v, input bit [1:0] op, input bit [15:0] arg,
                      input bit wr, input bit rd);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; fifo_wr_en = wr; fifo_rd_en = rd;
    model_step(v, op, arg, wr, rd);
    @(posedge clk); #1;
    cmd_valid = 1'b0; fifo_wr_en = 1'b0; fifo_rd_en = 1'b0;
    check_all();
    if (done === 1'b1) n_done++;
    if (start_write === 1'b1) n_start++;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; fifo_wr_en = 1'b0; fifo_rd_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check_all();
  endtask

  // Random capture traffic until the model returns to IDLE or ERROR
  task automatic run_capture(input int budget_max, input string tag);
    int  budget;
    bit  wr, rd;
    budget = 0;
    while (model_busy() && budget < budget_max) begin
      wr = (m_phase == PH_CAP) && ($urandom_range(0, 9) < 7) && (m_level < DEPTH - 2);
      rd = ($urandom_range(0, 1) == 1);
      step(1'b0, 2'd0, 16'd0, wr, rd);
      budget++;
    end
    chk(tag, (budget < budget_max) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic drain_idle();
    int guard;
    guard = 0;
    while (m_level > 0 && guard < 64) begin
      step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);
      guard++;
    end
  endtask

  initial begin
    int cnt;
    int d0;
    // Reset state
    do_reset();
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b1);  // read at level 0 is ignored

    // Default 64x64 capture with random interleaved reads
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    chk("start_pulse_default", start_write, 32'd1);
    d0 = n_done;
    run_capture(20000, "default_capture_budget");
    chk("default_done_once", n_done - d0, 32'd1);
    chk("default_pix", pix_count, 32'd4096);
    chk("default_err", err_code, 32'd0);

    // 8x2 window, random interleaving including same-cycle write+read
    step(1'b1, CMD_SET_WIDTH,  16'd8, 1'b0, 1'b0);
    step(1'b1, CMD_SET_HEIGHT, 16'd2, 1'b0, 1'b0);
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    d0 = n_done;
    run_capture(2000, "small_capture_budget");
    chk("small_done_once", n_done - d0, 32'd1);
    chk("small_pix", pix_count, 32'd16);

    // Zero width: bad config, no arm pulse, ABORT clears
    cnt = n_start;
    step(1'b1, CMD_SET_WIDTH, 16'd0, 1'b0, 1'b0);
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    chk("badcfg_err", err_code, 32'd3);
    chk("badcfg_no_arm", n_start - cnt, 32'd0);
    step(1'b1, CMD_ABORT, 16'd0, 1'b0, 1'b0);
    chk("abort_clears_err", err_code, 32'd0);
    chk("abort_not_busy", busy, 32'd0);

    // 8x8 window, 17 writes with no reads overflows the 16-deep FIFO
    step(1'b1, CMD_SET_WIDTH,  16'd8, 1'b0, 1'b0);
    step(1'b1, CMD_SET_HEIGHT, 16'd8, 1'b0, 1'b0);
    drain_idle();
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);  // ARM
    for (int i = 0; i < 16; i++) step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    chk("pre_ovf_err", err_code, 32'd0);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    chk("ovf_err", err_code, 32'd1);
    chk("ovf_level", fifo_level, 32'd16);
    chk("ovf_busy", busy, 32'd0);
    drain_idle();

    // Timeout after three writes, with a rejected SET_WIDTH mid-capture
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);  // ARM
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    step(1'b1, CMD_SET_WIDTH, 16'd99, 1'b0, 1'b0);
    chk("reject_pulse", cmd_rejected, 32'd1);
    chk("reject_cfg_kept", cfg_width, 32'd8);
    cnt = 1;
    while (err_code !== 2'd2 && cnt < 200) begin
      step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
      cnt++;
    end
    chk("timeout_cycles", cnt, TMO);
    chk("timeout_err", err_code, 32'd2);
    drain_idle();

    // ABORT mid-capture: IDLE next cycle, no done
    d0 = n_done;
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    step(1'b1, CMD_ABORT, 16'd0, 1'b0, 1'b0);
    chk("abort_idle", busy, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    chk("abort_no_done", n_done - d0, 32'd0);
    drain_idle();

    // Reset while draining
    step(1'b1, CMD_SET_WIDTH,  16'd2, 1'b0, 1'b0);
    step(1'b1, CMD_SET_HEIGHT, 16'd2, 1'b0, 1'b0);
    step(1'b1, CMD_START, 16'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
    chk("drain_busy", busy, 32'd1);
    do_reset();
    chk("rst_cfg_width", cfg_width, 32'd64);
    chk("rst_level", fifo_level, 32'd0);

    // Random command and FIFO traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
